regfile_sync: RTL and testbench

Synchronous-reset 32-entry x 32-bit MIPS-style register file with two asynchronous read ports and one clocked write port, built as the design-under-test responder to the `hw4testbench` driver. After reset, a clear sequencer zeroes registers 1..31 one per cycle and raises `Ready`. Register 0 is constant zero. An optional write-through bypass forwards in-flight write data to the read ports.

---
 rtl/regfile_sync.sv | 134 +++++++++++++
 tb/tb_regfile_sync.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_sync.sv
// 32 x 32 register file: two combinational read ports, one clocked write port,
// and a post-reset clear sweep. Define REGFILE_BYPASS_EN to forward in-flight write data to the read ports.
module regfile_sync #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    output logic                 Ready,
    output logic                 WriteIgnored
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] FIRST_INDEX = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] LAST_INDEX  = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   clear_index_reg, clear_index_next;
    logic                   ready_reg, ready_next;
    logic                   write_ignored_reg, write_ignored_next;

    logic [DEPTH-1:1]            entry_we;
    logic [WIDTH-1:0]            entry_wdata;
    logic [DEPTH-1:0][WIDTH-1:0] entry_q;

    logic [1:0][ADDR_BITS-1:0]   rd_addr;
    logic [1:0][WIDTH-1:0]       rd_data;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg         <= CLEAR;
            clear_index_reg   <= FIRST_INDEX;
            ready_reg         <= 1'b0;
            write_ignored_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            clear_index_reg   <= clear_index_next;
            ready_reg         <= ready_next;
            write_ignored_reg <= write_ignored_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        clear_index_next   = clear_index_reg;
        ready_next         = ready_reg;
        write_ignored_next = RegWrite && ((state_reg == CLEAR) || (WriteRegister == '0));
        case (state_reg)
            CLEAR: begin
                if (clear_index_reg == LAST_INDEX) begin
                    state_next       = RUN;
                    ready_next       = 1'b1;
                    clear_index_next = FIRST_INDEX;
                end else begin
                    clear_index_next = clear_index_reg + FIRST_INDEX;
                end
            end
            RUN: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: entry 0 is hard-wired zero, entries 1..DEPTH-1 are flops
    // ------------------------------------------------------------------
    assign entry_wdata = (state_reg == CLEAR) ? '0 : WriteData;
    assign entry_q[0]  = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] q_reg;

            // One-hot: the sweep owns the decoder in CLEAR, the write port in RUN.
            assign entry_we[gi] = !Reset &&
                (((state_reg == CLEAR) && (clear_index_reg == ADDR_BITS'(gi))) ||
                 ((state_reg == RUN) && RegWrite && (WriteRegister == ADDR_BITS'(gi))));

            always_ff @(posedge Clk) begin
                if (entry_we[gi]) begin
                    q_reg <= entry_wdata;
                end
            end

            assign entry_q[gi] = q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports: independent muxes, zero for address 0 or before Ready
    // ------------------------------------------------------------------
    assign rd_addr[0] = ReadRegister1;
    assign rd_addr[1] = ReadRegister2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                if (ready_reg && (rd_addr[gi] != '0)) begin
                    rd_data[gi] = entry_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                    if ((state_reg == RUN) && RegWrite && (WriteRegister == rd_addr[gi])) begin
                        rd_data[gi] = WriteData;
                    end
`endif
                end
            end
        end
    endgenerate

    assign ReadData1    = rd_data[0];
    assign ReadData2    = rd_data[1];
    assign Ready        = ready_reg;
    assign WriteIgnored = write_ignored_reg;

endmodule

// File: tb/tb_regfile_sync.sv
// Scoreboard bench for regfile_sync: stimulus queues expected port values,
// a negedge monitor pops and compares them.
module tb_regfile_sync;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, Ready, WriteIgnored;

    regfile_sync #(.WIDTH(32), .ADDR_BITS(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Ready         (Ready),
        .WriteIgnored  (WriteIgnored)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rdy;
        logic        ign;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    // Monitor: one queued expectation is consumed per falling edge.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks_total += 4;
            if (ReadData1 === e.rd1) checks_passed++;
            else $display("FAIL %s ReadData1: got %0h want %0h", e.name, ReadData1, e.rd1);
            if (ReadData2 === e.rd2) checks_passed++;
            else $display("FAIL %s ReadData2: got %0h want %0h", e.name, ReadData2, e.rd2);
            if (Ready === e.rdy) checks_passed++;
            else $display("FAIL %s Ready: got %b want %b", e.name, Ready, e.rdy);
            if (WriteIgnored === e.ign) checks_passed++;
            else $display("FAIL %s WriteIgnored: got %b want %b", e.name, WriteIgnored, e.ign);
            $display("check %-10s a1=%0d a2=%0d rd1=%0h rd2=%0h rdy=%b ign=%b", e.name,
                     ReadRegister1, ReadRegister2, ReadData1, ReadData2, Ready, WriteIgnored);
        end
    end

    // Called just after a rising edge (or falling edge); returns after the next falling edge.
    task automatic check(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic erdy, input logic eign, input string nm);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        exp_q.push_back('{nm, e1, e2, erdy, eign});
        @(negedge Clk);
        #1;
    endtask

    // Called after a falling edge; presents one write across the next rising edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic rw);
        WriteRegister = a;
        WriteData     = d;
        RegWrite      = rw;
        @(posedge Clk);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;

        // Reset at E0, then the sweep E1..E31; a CLEAR-time write to r5 at E10.
        @(posedge Clk); #1;
        Reset = 1'b0;
        check(5'd1, 5'd2, 32'd0, 32'd0, 1'b0, 1'b0, "reset");
        for (int k = 1; k <= 31; k++) begin
            if (k == 10) begin
                WriteRegister = 5'd5; WriteData = 32'd99; RegWrite = 1'b1;
            end
            @(posedge Clk); #1;
            RegWrite = 1'b0;
            check(5'd5, 5'(k), 32'd0, 32'd0, (k == 31), (k == 10), "sweep");
        end
        for (int i = 1; i <= 31; i++)
            check(5'(i), 5'(32 - i), 32'd0, 32'd0, 1'b1, 1'b0, "cleared");

        // Write, overwrite, write enable, decoder
        do_write(5'd2, 32'd42, 1'b1);
        check(5'd2, 5'd2, 32'd42, 32'd42, 1'b1, 1'b0, "wr_r2");
        do_write(5'd2, 32'd15, 1'b1);
        check(5'd2, 5'd2, 32'd15, 32'd15, 1'b1, 1'b0, "ovwr_r2");
        do_write(5'd3, 32'd20, 1'b0);
        check(5'd3, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0, "we_off");
        do_write(5'd4, 32'd25, 1'b1);
        check(5'd10, 5'd11, 32'd0, 32'd0, 1'b1, 1'b0, "decode");
        check(5'd4, 5'd4, 32'd25, 32'd25, 1'b1, 1'b0, "wr_r4");

        // Register 0 write is discarded with a single-cycle WriteIgnored pulse
        do_write(5'd0, 32'd30, 1'b1);
        check(5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, "r0_ign");
        check(5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, "r0_pulse");

        // Port independence
        do_write(5'd30, 32'd11, 1'b1);
        do_write(5'd17, 32'd17, 1'b1);
        check(5'd17, 5'd30, 32'd17, 32'd11, 1'b1, 1'b0, "ports");

        // Write of 7 to r30 held across the sampling edge: visible early only with bypass
        @(posedge Clk); #1;
        WriteRegister = 5'd30; WriteData = 32'd7; RegWrite = 1'b1;
`ifdef REGFILE_BYPASS_EN
        check(5'd17, 5'd30, 32'd17, 32'd7, 1'b1, 1'b0, "bypass");
`else
        check(5'd17, 5'd30, 32'd17, 32'd11, 1'b1, 1'b0, "no_bypass");
`endif
        @(posedge Clk); #1;
        RegWrite = 1'b0;
        check(5'd30, 5'd30, 32'd7, 32'd7, 1'b1, 1'b0, "wr_r30");

        // Reset from RUN with a discardable write at the reset edge, then mid-sweep reset at index 12
        Reset = 1'b1; WriteRegister = 5'd0; RegWrite = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; RegWrite = 1'b0;
        check(5'd2, 5'd30, 32'd0, 32'd0, 1'b0, 1'b0, "reset2");
        repeat (11) @(posedge Clk);
        #1;
        Reset = 1'b1; WriteRegister = 5'd0; RegWrite = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; RegWrite = 1'b0;
        check(5'd2, 5'd30, 32'd0, 32'd0, 1'b0, 1'b0, "reset_mid");
        for (int k = 1; k <= 31; k++) begin
            @(posedge Clk); #1;
            check(5'd30, 5'd2, 32'd0, 32'd0, (k == 31), 1'b0, "resweep");
        end
        do_write(5'd6, 32'd123, 1'b1);
        check(5'd6, 5'd6, 32'd123, 32'd123, 1'b1, 1'b0, "wr_r6");

        // Drain the scoreboard within a bounded number of cycles
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            checks_total++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
